// File: rtl/arm_pkg.sv
// Shared execute-command encodings and NZCV flag-vector type for the ARM-style datapath.
package arm_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exec_cmd_e;

  // Compare and test reuse the arithmetic/logical encodings; only the S bit matters here.
  localparam logic [3:0] CMD_CMP = CMD_SUB;
  localparam logic [3:0] CMD_TST = CMD_AND;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam logic [3:0] MASK_ARITH = 4'b1111;
  localparam logic [3:0] MASK_LOGIC = 4'b1110;
  localparam logic [3:0] MASK_NONE  = 4'b0000;

endpackage

// File: rtl/flag_calc.sv
// Combinational NZCV evaluation for one execute command; update_mask marks which flags it may change.
module flag_calc
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             shifter_c,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv,
  output logic [3:0]       update_mask
);

  logic [WIDTH-1:0] b_op;
  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic             is_arith;
  flags_t           f;

  always_comb begin
    b_op     = b;
    carry_in = 1'b0;
    is_arith = 1'b0;
    result   = '0;
    update_mask = MASK_NONE;
    case (cmd)
      CMD_ADD: begin is_arith = 1'b1; end
      CMD_ADC: begin is_arith = 1'b1; carry_in = c_in; end
      CMD_SUB: begin is_arith = 1'b1; b_op = ~b; carry_in = 1'b1; end
      CMD_SBC: begin is_arith = 1'b1; b_op = ~b; carry_in = c_in; end
      default: ;
    endcase

    sum = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, carry_in};

    f = '0;
    case (cmd)
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        result      = sum[WIDTH-1:0];
        update_mask = MASK_ARITH;
      end
      CMD_AND: begin result = a & b; update_mask = MASK_LOGIC; end
      CMD_ORR: begin result = a | b; update_mask = MASK_LOGIC; end
      CMD_EOR: begin result = a ^ b; update_mask = MASK_LOGIC; end
      CMD_MOV: begin result = b;     update_mask = MASK_LOGIC; end
      CMD_MVN: begin result = ~b;    update_mask = MASK_LOGIC; end
      default: ;
    endcase

    f.n = result[WIDTH-1];
    f.z = (result == '0);
    // Subtract carry is the inverted borrow, which falls straight out of a + ~b + 1.
    f.c = is_arith ? sum[WIDTH] : shifter_c;
    f.v = is_arith && (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    nzcv = f;
  end

endmodule

// File: rtl/status_register_unit.sv
// Two-stage NZCV producer: stage 1 captures flag-setting instructions, stage 2 writes the status register.
module status_register_unit
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_s,
  input  logic [3:0]       ex_cmd,
  input  logic [WIDTH-1:0] ex_a,
  input  logic [WIDTH-1:0] ex_b,
  input  logic             shifter_c,
  input  logic             freeze,
  input  logic             flush,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             flags_pending
);

  logic             vld_p1;
  logic             written_p1;
  logic [3:0]       cmd_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic             sc_p1;
  logic [3:0]       flags_q;
  logic [3:0]       calc_nzcv;
  logic [3:0]       calc_mask;
  logic             do_write;
  logic             capture;

  assign capture  = ex_valid && ex_s && !freeze;
  assign do_write = vld_p1 && !written_p1;

  // Stage 1: capture operands of a flag-setting instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      written_p1 <= 1'b0;
      cmd_p1     <= '0;
      a_p1       <= '0;
      b_p1       <= '0;
      sc_p1      <= 1'b0;
    end else begin
      written_p1 <= written_p1 | do_write;
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (freeze) begin
        vld_p1 <= vld_p1;
      end else if (capture) begin
        vld_p1     <= 1'b1;
        written_p1 <= 1'b0;
        cmd_p1     <= ex_cmd;
        a_p1       <= ex_a;
        b_p1       <= ex_b;
        sc_p1      <= shifter_c;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  flag_calc #(.WIDTH(WIDTH)) u_calc (
    .cmd         (cmd_p1),
    .a           (a_p1),
    .b           (b_p1),
    .shifter_c   (sc_p1),
    .c_in        (flags_q[1]),
    .result      (),
    .nzcv        (calc_nzcv),
    .update_mask (calc_mask)
  );

  // Stage 2: merge computed flags into the architectural register
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else if (do_write) begin
      flags_q <= (flags_q & ~calc_mask) | (calc_nzcv & calc_mask);
    end
  end

  assign N             = flags_q[3];
  assign Z             = flags_q[2];
  assign C             = flags_q[1];
  assign V             = flags_q[0];
  assign flags_pending = vld_p1;

endmodule

// File: tb/tb_status_register_unit.sv
// Directed bench for status_register_unit with immediate-assertion checks.
module tb_status_register_unit;
  import arm_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic             ex_s;
  logic [3:0]       ex_cmd;
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic             shifter_c;
  logic             freeze;
  logic             flush;
  logic             N, Z, C, V;
  logic             flags_pending;

  int n_assert = 0;
  int n_fail   = 0;

  status_register_unit #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_s          (ex_s),
    .ex_cmd        (ex_cmd),
    .ex_a          (ex_a),
    .ex_b          (ex_b),
    .shifter_c     (shifter_c),
    .freeze        (freeze),
    .flush         (flush),
    .N             (N),
    .Z             (Z),
    .C             (C),
    .V             (V),
    .flags_pending (flags_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp_nzcv, input logic exp_pend);
    n_assert++;
    assert ({N, Z, C, V} === exp_nzcv)
    else begin
      n_fail++;
      $error("FAIL %s nzcv: observed %b expected %b", tag, {N, Z, C, V}, exp_nzcv);
    end
    n_assert++;
    assert (flags_pending === exp_pend)
    else begin
      n_fail++;
      $error("FAIL %s pending: observed %b expected %b", tag, flags_pending, exp_pend);
    end
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic sc);
    ex_valid  = 1'b1;
    ex_s      = 1'b1;
    ex_cmd    = cmd;
    ex_a      = a;
    ex_b      = b;
    shifter_c = sc;
  endtask

  task automatic idle();
    ex_valid  = 1'b0;
    ex_s      = 1'b0;
    shifter_c = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    freeze = 1'b0;
    flush  = 1'b0;
    issue(CMD_ADD, 32'h1, 32'h1, 1'b1);

    // Reset held two cycles with a valid flag-setting instruction present
    step(); check("reset_c1", 4'b0000, 1'b0);
    step(); check("reset_c2", 4'b0000, 1'b0);
    rst = 1'b0;
    idle();
    step(); check("post_reset", 4'b0000, 1'b0);

    // ADD overflow: 0x7FFFFFFF + 1
    issue(CMD_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
    step(); idle();
    check("add_ovf_pend", 4'b0000, 1'b1);
    step(); check("add_ovf_flags", 4'b1001, 1'b0);
    step(); check("add_ovf_hold", 4'b1001, 1'b0);

    // SUB 5-5 followed back-to-back by ADC 0xFFFFFFFF+0 consuming C=1
    issue(CMD_SUB, 32'd5, 32'd5, 1'b0);
    step(); check("sub_pend", 4'b1001, 1'b1);
    issue(CMD_ADC, 32'hFFFF_FFFF, 32'h0, 1'b0);
    step(); idle();
    check("sub_zero", 4'b0110, 1'b1);
    step(); check("adc_chain", 4'b0110, 1'b0);

    // Set V with ADD, then EOR with shifter_c=1 leaves V alone
    issue(CMD_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
    step();
    issue(CMD_EOR, 32'hF000_0000, 32'h0, 1'b1);
    step(); idle();
    check("add_before_eor", 4'b1001, 1'b1);
    step(); check("eor_keep_v", 4'b1011, 1'b0);

    // CMP dropped by a same-cycle flush
    issue(CMD_CMP, 32'd1, 32'd1, 1'b0);
    flush = 1'b1;
    step(); idle(); flush = 1'b0;
    check("cmp_flush_pend", 4'b1011, 1'b0);
    step(); check("cmp_flush_flags", 4'b1011, 1'b0);

    // Flush after capture: stage 2 still commits the already-captured update
    issue(CMD_CMP, 32'd1, 32'd1, 1'b0);
    step(); idle();
    flush = 1'b1;
    check("late_flush_pend", 4'b1011, 1'b1);
    step(); flush = 1'b0;
    check("late_flush_commit", 4'b0110, 1'b0);

    // Unknown command with S set leaves flags alone
    issue(4'b1111, 32'd0, 32'd0, 1'b1);
    step(); idle();
    check("unknown_pend", 4'b0110, 1'b1);
    step(); check("unknown_flags", 4'b0110, 1'b0);

    // Freeze for 3 cycles over SUB 3-4
    issue(CMD_SUB, 32'd3, 32'd4, 1'b0);
    step(); idle(); freeze = 1'b1;
    check("frz_sub_c0", 4'b0110, 1'b1);
    step(); check("frz_sub_c1", 4'b1000, 1'b1);
    step(); check("frz_sub_c2", 4'b1000, 1'b1);
    step(); freeze = 1'b0;
    check("frz_sub_c3", 4'b1000, 1'b1);
    step(); check("frz_sub_release", 4'b1000, 1'b0);

    // Freeze over ADC: a repeated write would see the new C and change the flags
    issue(CMD_ADC, 32'hFFFF_FFFF, 32'h1, 1'b0);
    step(); idle(); freeze = 1'b1;
    check("frz_adc_c0", 4'b1000, 1'b1);
    step(); check("frz_adc_c1", 4'b0110, 1'b1);
    step(); check("frz_adc_c2", 4'b0110, 1'b1);
    step(); freeze = 1'b0;
    check("frz_adc_c3", 4'b0110, 1'b1);
    step(); check("frz_adc_release", 4'b0110, 1'b0);

    // Freeze blocks a new capture
    freeze = 1'b1;
    issue(CMD_MOV, 32'd0, 32'h8000_0000, 1'b0);
    step(); idle(); freeze = 1'b0;
    check("frz_no_capture", 4'b0110, 1'b0);
    step(); check("frz_no_capture_flags", 4'b0110, 1'b0);

    // Reset mid-flight discards the pending update
    issue(CMD_MVN, 32'd0, 32'd0, 1'b1);
    step(); idle();
    check("mid_reset_pend", 4'b0110, 1'b1);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("mid_reset_edge", 4'b0000, 1'b0);
    step(); check("mid_reset_after", 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/status_register_unit.md
# status_register_unit

Producer side of the NZCV condition flags. Takes the execute-stage command, operands and S bit, computes N, Z, C, V in a two-stage pipeline and holds them in the architectural status register whose outputs feed the condition checker in decode. A pending indicator lets the hazard unit stall condition-dependent instructions while a flag update is in flight.

## Interface
Parameters:
- WIDTH, 32, datapath width of operands and result

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  an instruction is present in execute this cycle
- ex_s  in  1  instruction's S bit (update flags)
- ex_cmd  in  4  execute command (encoding in package)
- ex_a  in  WIDTH  first operand (Rn value)
- ex_b  in  WIDTH  second operand (shifter output)
- shifter_c  in  1  shifter carry-out, used by logical commands
- freeze  in  1  hazard stall: hold stage 1, no new capture
- flush  in  1  branch-taken flush: kill stage 1 contents
- N, Z, C, V  out  1 each  architectural flags (registered)
- flags_pending  out  1  stage 1 holds a flag-setting instruction

## Operation
- Stage 1 (capture): when ex_valid && ex_s && !freeze, latch cmd, a, b, shifter_c and set s1_valid. When freeze, hold everything. Otherwise s1_valid clears.
- flush has priority over capture and freeze: s1_valid forced to 0 next edge.
- Stage 2 (compute/write): if s1_valid, compute 33-bit sum and write all affected flags to the status register at the next edge.
- Arithmetic, zero-extended to WIDTH+1:
  - ADD: a+b; ADC: a+b+C (current architectural C); SUB/CMP: a+~b+1; SBC: a+~b+C.
  - C = bit WIDTH of the 33-bit sum (SUB: C=1 means no borrow).
  - V = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), b' = b or ~b as used.
- Logical (AND/TST, ORR, EOR, MOV, MVN): result per command; C = captured shifter_c; V unchanged.
- All commands: N = result[MSB], Z = (result == 0).
- Unknown command codes with S set: no flag change (s1 entry discarded).
- ADC/SBC read C at stage 2 time, so back-to-back flag-setting ops chain correctly.
- flags_pending = s1_valid (combinational from register).

## Timing
- Reset: N=Z=C=V=0, s1_valid=0, flags_pending=0, stage 1 data regs 0.
- Latency: instruction presented at edge k (ex_valid, ex_s high) -> flags_pending high in cycle k+1 -> NZCV updated visible after edge k+2.
- Throughput: one flag-setting instruction per cycle; stage 2 writes while stage 1 captures the next.
- flush in same cycle as capture: instruction dropped; stage 2 still completes any update already committed in the cycle it was computed (flush only affects stage 1).
- freeze with s1_valid=1: stage 2 writes once, then stage 1 holds but s1_valid must not write again; implement via a one-shot "written" bit cleared on new capture.
- Reset mid-operation: all in-flight updates discarded; flags return to 0 on the reset edge.

## Structure
- Shared package arm_pkg: exec command typedef/constants (MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000; CMP shares SUB, TST shares AND), flag-vector typedef {N,Z,C,V}.
- One sub-module: flag_calc (pure combinational, cmd/a/b/shifter_c/c_in -> result, nzcv, update_mask). Pipeline and status register live in the top.

## Test plan
- Reset: hold rst 2 cycles with ex_valid=1, ex_s=1 -> NZCV=0000, flags_pending=0 throughout.
- ADD 0x7FFFFFFF+1, S=1 -> two cycles later N=1,Z=0,C=0,V=1; flags_pending high exactly one cycle.
- SUB 5-5 then ADC 0xFFFFFFFF+0 back-to-back -> first gives Z=1,C=1; second uses C=1 -> result 0, Z=1,C=1,V=0.
- EOR with shifter_c=1 after V set -> N/Z per result, C=1, V retained 1.
- CMP captured with flush same cycle -> NZCV unchanged, flags_pending stays 0.
- freeze held 3 cycles over a pending SUB 3-4 -> single update N=1,C=0, flags_pending high for the frozen cycles, no repeated write.
